// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared frame defaults, field positions and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int FRAME_W_DEFAULT = 24;

  // Command/address byte followed by a 16-bit data word
  localparam int ADDR_HI = 23;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_master_ctrl_if.sv
// ============================================================================
// Module      : spi_master_ctrl_if
// Description : Command/response handshake plus SPI pins of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_master_ctrl_if #(
  parameter int FRAME_W = spi_pkg::FRAME_W_DEFAULT
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [FRAME_W-1:0] cmd_data;
  logic               rsp_valid;
  logic [FRAME_W-1:0] rsp_data;
  logic               busy;
  logic               sck;
  logic               mosi;
  logic               miso;
  logic               cs;

  modport master (
    input  cmd_valid, cmd_data, miso,
    output cmd_ready, rsp_valid, rsp_data, busy, sck, mosi, cs
  );

  modport slave (
    output cmd_valid, cmd_data, miso,
    input  cmd_ready, rsp_valid, rsp_data, busy, sck, mosi, cs
  );
endinterface

`default_nettype wire

// File: rtl/spi_sck_gen.sv
// ============================================================================
// Module      : spi_sck_gen
// Description : Phase/bit counters, registered SCK and edge strobes for the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int FRAME_W  = FRAME_W_DEFAULT,
  parameter int HALF_PER = 4,
  parameter int CS_GUARD = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire spi_state_t i_state,
  output logic            o_phase_end,
  output logic            o_last_bit,
  output logic            o_rise_stb,
  output logic            o_fall_stb,
  output logic            o_sck
);

  localparam int                 c_BIT_W     = $clog2(FRAME_W + 1);
  localparam logic [7:0]         c_GUARD_LIM = 8'(CS_GUARD - 1);
  localparam logic [7:0]         c_HALF_LIM  = 8'(HALF_PER - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(FRAME_W - 1);

  logic [7:0]         r_phase;
  logic [c_BIT_W-1:0] r_bitcnt;
  logic               r_sck;
  logic               w_timed;
  logic [7:0]         w_limit;

  always_comb begin
    w_timed = 1'b0;
    w_limit = c_HALF_LIM;
    case (i_state)
      ST_SETUP, ST_HOLD: begin
        w_timed = 1'b1;
        w_limit = c_GUARD_LIM;
      end
      ST_SHIFT_LO, ST_SHIFT_HI: w_timed = 1'b1;
      default: ;
    endcase
  end

  assign o_phase_end = w_timed && (r_phase == w_limit);
  assign o_last_bit  = (r_bitcnt == c_LAST_BIT);
  assign o_rise_stb  = o_phase_end && (i_state == ST_SHIFT_LO);
  // The final SHIFT_HI exit leaves SCK high for the hold phase
  assign o_fall_stb  = o_phase_end &&
                       ((i_state == ST_SETUP) || ((i_state == ST_SHIFT_HI) && !o_last_bit));
  assign o_sck       = r_sck;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= 8'd0;
      r_bitcnt <= '0;
      r_sck    <= 1'b1;
    end else begin
      if (!w_timed || o_phase_end) begin
        r_phase <= 8'd0;
      end else begin
        r_phase <= r_phase + 8'd1;
      end

      if (i_state == ST_IDLE) begin
        r_bitcnt <= '0;
      end else if (o_phase_end && (i_state == ST_SHIFT_HI)) begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end

      if (i_state == ST_IDLE) begin
        r_sck <= 1'b1;
      end else if (o_fall_stb) begin
        r_sck <= 1'b0;
      end else if (o_rise_stb) begin
        r_sck <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI mode-3 style frame master: FSM, TX/RX shift registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W  = FRAME_W_DEFAULT,
  parameter int HALF_PER = 4,
  parameter int CS_GUARD = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  spi_master_ctrl_if.master bus
);

  spi_state_t         r_state;
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_rx;
  logic [FRAME_W-1:0] r_rsp_data;
  logic               r_cs;
  logic               r_mosi;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic               r_busy;

  logic w_phase_end;
  logic w_last_bit;
  logic w_rise_stb;
  logic w_fall_stb;
  logic w_sck;

  spi_sck_gen #(
    .FRAME_W  (FRAME_W),
    .HALF_PER (HALF_PER),
    .CS_GUARD (CS_GUARD)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .i_state     (r_state),
    .o_phase_end (w_phase_end),
    .o_last_bit  (w_last_bit),
    .o_rise_stb  (w_rise_stb),
    .o_fall_stb  (w_fall_stb),
    .o_sck       (w_sck)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_cs        <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_tx        <= bus.cmd_data;
            r_rx        <= '0;
            r_cs        <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: if (w_phase_end) r_state <= ST_SHIFT_LO;
        ST_SHIFT_LO: if (w_phase_end) r_state <= ST_SHIFT_HI;
        ST_SHIFT_HI: begin
          if (w_phase_end) begin
            r_tx    <= r_tx << 1;
            r_state <= w_last_bit ? ST_HOLD : ST_SHIFT_LO;
          end
        end
        ST_HOLD: begin
          if (w_phase_end) begin
            r_cs        <= 1'b1;
            r_rsp_data  <= r_rx;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // MOSI presents the bit about to be sent; mid-frame falls see TX before its shift lands
      if (w_fall_stb) begin
        r_mosi <= (r_state == ST_SETUP) ? r_tx[FRAME_W-1] : r_tx[FRAME_W-2];
      end
      if (w_rise_stb) begin
        r_rx <= {r_rx[FRAME_W-2:0], bus.miso};
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;
  assign bus.sck       = w_sck;
  assign bus.mosi      = r_mosi;
  assign bus.cs        = r_cs;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// ============================================================================
// Module      : tb_spi_master_ctrl
// Description : Directed bench: loopback, register-file slave, back-to-back,
//               mid-frame reset and fastest-timing variant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst_q = 1'b1;
  logic use_slave;
  logic s_miso = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  spi_master_ctrl_if #(.FRAME_W(24)) a_if ();
  spi_master_ctrl_if #(.FRAME_W(24)) b_if ();

  spi_master_ctrl #(.FRAME_W(24), .HALF_PER(4), .CS_GUARD(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.master)
  );

  spi_master_ctrl #(.FRAME_W(24), .HALF_PER(1), .CS_GUARD(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.master)
  );

  assign a_if.miso = use_slave ? s_miso : a_if.mosi;
  assign b_if.miso = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural slave: cmd bit7=1 read, else write; low nibble selects one of 16 regs
  logic [15:0] regs [16];
  logic [23:0] s_sh = '0;
  logic [7:0]  s_cmd = '0;
  int          s_cnt = 0;
  logic        s_prev_sck = 1'b1;
  logic        s_prev_cs = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) regs[n] <= 16'(n * 17);
      s_cnt <= 0;
    end else if (a_if.cs === 1'b1) begin
      if (!s_prev_cs && s_cnt == 24 && !s_cmd[7]) regs[s_cmd[3:0]] <= s_sh[15:0];
      s_cnt <= 0;
    end else begin
      if (s_prev_sck && a_if.sck === 1'b0) begin
        s_miso <= (s_cnt >= 8 && s_cmd[7]) ? regs[s_cmd[3:0]][23 - s_cnt] : 1'b0;
      end
      if (!s_prev_sck && a_if.sck === 1'b1) begin
        s_sh  <= {s_sh[22:0], a_if.mosi};
        s_cnt <= s_cnt + 1;
        if (s_cnt == 7) s_cmd <= {s_sh[6:0], a_if.mosi};
      end
    end
    s_prev_sck <= a_if.sck;
    s_prev_cs  <= a_if.cs;
  end

  // Protocol monitor on the default-timing instance
  int   mon_rises = 0;
  logic m_prev_sck = 1'b1;
  logic m_prev_cs = 1'b1;
  logic m_prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst_q) begin
      mon_rises <= 0;
    end else if (a_if.cs === 1'b1) begin
      check("mon_sck_high_when_cs_high", a_if.sck, 1);
      if (!m_prev_cs) check("mon_sck_rises_per_frame", mon_rises, 24);
      mon_rises <= 0;
    end else begin
      if (m_prev_sck && a_if.sck === 1'b1) check("mon_mosi_stable", a_if.mosi, m_prev_mosi);
      if (!m_prev_sck && a_if.sck === 1'b1) mon_rises <= mon_rises + 1;
    end
    m_prev_sck  <= a_if.sck;
    m_prev_cs   <= a_if.cs;
    m_prev_mosi <= a_if.mosi;
  end

  task automatic run_frame(input logic [23:0] d, output int lat, output logic [23:0] rd);
    int n;
    n = 0;
    while (a_if.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("frame_ready_wait", a_if.cmd_ready, 1);
    a_if.cmd_data  = d;
    a_if.cmd_valid = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        a_if.cmd_valid = 1'b0;
        check("frame_cs_low_at_handshake", a_if.cs, 0);
      end
    end while (a_if.rsp_valid !== 1'b1 && lat < 400);
    rd = a_if.rsp_data;
    tick();
  endtask

  initial begin
    int          lat;
    int          hs;
    int          pulses;
    int          busy_rdy;
    int          rises;
    int          rv_cnt;
    int          tg;
    int          first_t;
    int          last_t;
    int          hs_c [2];
    int          rv_t [2];
    logic [23:0] rv_d [2];
    logic [23:0] rd;
    logic        rdy_before;
    logic        vld_before;
    logic        prev;

    rst = 1'b1;
    use_slave = 1'b0;
    a_if.cmd_valid = 1'b0;
    a_if.cmd_data  = '0;
    b_if.cmd_valid = 1'b0;
    b_if.cmd_data  = '0;
    repeat (3) tick();

    check("rst_cs", a_if.cs, 1);
    check("rst_sck", a_if.sck, 1);
    check("rst_mosi", a_if.mosi, 0);
    check("rst_cmd_ready", a_if.cmd_ready, 0);
    check("rst_rsp_valid", a_if.rsp_valid, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_rsp_data", a_if.rsp_data, 0);
    check("rst_b_cs", b_if.cs, 1);

    rst = 1'b0;
    tick();
    check("ready_first_edge_after_rst", a_if.cmd_ready, 1);

    // Loopback at default timing
    run_frame(24'h05BEEF, lat, rd);
    check("loop_latency", lat, 197);
    check("loop_rsp_data", rd, 24'h05BEEF);
    check("loop_rsp_valid_one_cycle", a_if.rsp_valid, 0);
    check("loop_idle_ready", a_if.cmd_ready, 1);
    check("loop_idle_busy", a_if.busy, 0);
    check("loop_rsp_hold", a_if.rsp_data, 24'h05BEEF);

    // Write then read through the register-file slave
    use_slave = 1'b1;
    run_frame(24'h05BEEF, lat, rd);
    check("slave_reg5_written", regs[5], 16'hBEEF);
    run_frame(24'h850000, lat, rd);
    check("slave_read5_data", rd[15:0], 16'hBEEF);
    run_frame(24'h830000, lat, rd);
    check("slave_read3_data", rd[15:0], 16'h0033);
    check("slave_read3_cmd_bits", rd[23:16], 8'h00);
    use_slave = 1'b0;

    // cmd_valid held across two frames
    hs = 0;
    pulses = 0;
    busy_rdy = 0;
    hs_c[0] = -1; hs_c[1] = -1; rv_t[0] = -1; rv_t[1] = -1;
    rv_d[0] = '0; rv_d[1] = '0;
    a_if.cmd_data  = 24'h123456;
    a_if.cmd_valid = 1'b1;
    for (int i = 1; i <= 420; i++) begin
      rdy_before = a_if.cmd_ready;
      vld_before = a_if.cmd_valid;
      tick();
      if (rdy_before && vld_before) begin
        if (hs < 2) hs_c[hs] = i - 1;
        hs++;
        if (hs == 1) a_if.cmd_data = 24'hA5C33C;
        else a_if.cmd_valid = 1'b0;
      end
      if (a_if.rsp_valid) begin
        if (pulses < 2) begin
          rv_t[pulses] = i;
          rv_d[pulses] = a_if.rsp_data;
        end
        pulses++;
      end
      if (a_if.busy && a_if.cmd_ready) busy_rdy++;
    end
    a_if.cmd_valid = 1'b0;
    check("b2b_handshakes", hs, 2);
    check("b2b_rsp_pulses", pulses, 2);
    check("b2b_ready_while_busy", busy_rdy, 0);
    check("b2b_first_latency", rv_t[0] - hs_c[0], 197);
    check("b2b_second_hs_gap", hs_c[1] - rv_t[0], 1);
    check("b2b_second_latency", rv_t[1] - hs_c[1], 197);
    check("b2b_data0", rv_d[0], 24'h123456);
    check("b2b_data1", rv_d[1], 24'hA5C33C);

    // Reset during bit 10 aborts the frame
    a_if.cmd_data  = 24'h3C5A96;
    a_if.cmd_valid = 1'b1;
    tick();
    a_if.cmd_valid = 1'b0;
    rises = 0;
    for (int i = 0; i < 300 && rises < 10; i++) begin
      prev = a_if.sck;
      tick();
      if (!prev && a_if.sck) rises++;
    end
    check("abort_reached_bit10", rises, 10);
    check("abort_cs_low_before_rst", a_if.cs, 0);
    rst = 1'b1;
    tick();
    check("abort_cs", a_if.cs, 1);
    check("abort_sck", a_if.sck, 1);
    check("abort_busy", a_if.busy, 0);
    check("abort_rsp_valid", a_if.rsp_valid, 0);
    rst = 1'b0;
    rv_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      tick();
      if (a_if.rsp_valid) rv_cnt++;
    end
    check("abort_no_rsp_pulse", rv_cnt, 0);
    run_frame(24'h3C5A96, lat, rd);
    check("abort_next_latency", lat, 197);
    check("abort_next_data", rd, 24'h3C5A96);

    // Fastest timing: HALF_PER=1, CS_GUARD=1, MISO stuck high
    check("fast_ready", b_if.cmd_ready, 1);
    b_if.cmd_data  = 24'h000000;
    b_if.cmd_valid = 1'b1;
    lat = 0;
    tg = 0;
    first_t = -1;
    last_t = -1;
    prev = b_if.sck;
    do begin
      tick();
      lat++;
      if (lat == 1) b_if.cmd_valid = 1'b0;
      if (b_if.sck !== prev) begin
        tg++;
        if (first_t < 0) first_t = lat;
        last_t = lat;
      end
      prev = b_if.sck;
    end while (b_if.rsp_valid !== 1'b1 && lat < 200);
    check("fast_latency", lat, 51);
    check("fast_rsp_data", b_if.rsp_data, 24'hFFFFFF);
    check("fast_sck_toggles", tg, 48);
    check("fast_sck_every_cycle", last_t - first_t, 47);
    tick();
    check("fast_back_to_idle", b_if.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
